ssd_template_tracker: RTL and testbench

Streaming sum-of-squared-differences (SSD) template matcher. It scores every TMPL x TMPL window of a raster-order frame against a loaded template and reports the lowest-score window position once the frame ends. It sits between the static frame BRAM reader and the tracking/overlay logic. It generalises the fixed 3x3, 4-bit, 640x480 matcher: template size, pixel width and image size are parameters, and it adds a template-load port, a valid/stall stream, a frame-start handshake and a reported score with a valid flag.

---
 rtl/ssd_pkg.sv | 17 +
 rtl/tmpl_window_buffer.sv | 50 +++++
 rtl/ssd_template_tracker.sv | 210 +++++++++++++++++++++
 tb/tb_ssd_template_tracker.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared types and sizing helpers for the SSD template tracker and its frame source.
package ssd_pkg;

    localparam int unsigned DEF_IMG_W = 640;
    localparam int unsigned DEF_IMG_H = 480;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush
    } state_e;

    function automatic int unsigned score_width(int unsigned pix_w, int unsigned tmpl);
        return 2 * pix_w + $clog2(tmpl * tmpl);
    endfunction

endpackage

// File: rtl/tmpl_window_buffer.sv
// Sliding TMPL x TMPL window over a raster stream: TMPL-1 line buffers feed a register array.
module tmpl_window_buffer #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned TMPL  = 3,
    parameter int unsigned PIX_W = 4
) (
    input  logic                          clk,
    input  logic                          i_en,
    input  logic [$clog2(IMG_W)-1:0]      i_col,
    input  logic [PIX_W-1:0]              i_pix,
    output logic [TMPL*TMPL*PIX_W-1:0]    o_win
);

    logic [PIX_W-1:0] r_line [TMPL-1][IMG_W];
    logic [PIX_W-1:0] r_win  [TMPL][TMPL];
    logic [PIX_W-1:0] w_col  [TMPL];

    // Bottom window row is the live pixel; line k holds the row k+1 above it.
    always_comb begin
        w_col[TMPL-1] = i_pix;
        for (int k = 1; k < TMPL; k++) begin
            w_col[TMPL-1-k] = r_line[k-1][i_col];
        end
    end

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_line[0][i_col] <= i_pix;
            for (int k = 1; k < TMPL - 1; k++) begin
                r_line[k][i_col] <= r_line[k-1][i_col];
            end
            for (int r = 0; r < TMPL; r++) begin
                for (int c = 0; c < TMPL - 1; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
                r_win[r][TMPL-1] <= w_col[r];
            end
        end
    end

    always_comb begin
        o_win = '0;
        for (int r = 0; r < TMPL; r++) begin
            for (int c = 0; c < TMPL; c++) begin
                o_win[(r*TMPL+c)*PIX_W +: PIX_W] = r_win[r][c];
            end
        end
    end

endmodule

// File: rtl/ssd_template_tracker.sv
// Streaming SSD template matcher: scores every complete window of a raster frame and
// reports the lowest-score window centre when the frame ends.
module ssd_template_tracker
    import ssd_pkg::*;
#(
    parameter int unsigned IMG_W  = DEF_IMG_W,
    parameter int unsigned IMG_H  = DEF_IMG_H,
    parameter int unsigned TMPL   = 3,
    parameter int unsigned PIX_W  = 4,
    parameter int unsigned MARGIN = 10
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_start,
    input  logic                                 i_pix_valid,
    input  logic [PIX_W-1:0]                     i_pix,
    input  logic                                 i_tmpl_we,
    input  logic [$clog2(TMPL*TMPL)-1:0]         i_tmpl_addr,
    input  logic [PIX_W-1:0]                     i_tmpl_data,
    input  logic                                 i_track_en,
    input  logic [9:0]                           i_left,
    input  logic [9:0]                           i_right,
    input  logic [9:0]                           i_top,
    input  logic [9:0]                           i_bottom,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_best_valid,
    output logic [9:0]                           o_best_x,
    output logic [9:0]                           o_best_y,
    output logic [score_width(PIX_W, TMPL)-1:0]  o_best_score
);

    localparam int unsigned NTAP    = TMPL * TMPL;
    localparam int unsigned SCORE_W = score_width(PIX_W, TMPL);
    localparam int unsigned XW      = $clog2(IMG_W);
    localparam int unsigned YW      = $clog2(IMG_H);
    localparam int unsigned HALF    = (TMPL - 1) / 2;

    state_e                   r_state, w_state_d;
    logic                     w_clear, w_accept, w_finish, w_last;
    logic [XW-1:0]            r_x;
    logic [YW-1:0]            r_y;
    logic [PIX_W-1:0]         r_tmpl [NTAP];
    logic [NTAP*PIX_W-1:0]    w_win;
    logic [15:0]              w_cx, w_cy;
    logic                     w_complete, w_in_margin, w_in_box, w_qual;
    logic                     r_cand_v;
    logic [9:0]               r_cand_x, r_cand_y;
    logic [SCORE_W-1:0]       w_score, r_min;
    logic [9:0]               r_min_x, r_min_y;
    logic                     r_found, w_upd;
    logic                     r_busy, r_done, r_best_valid;
    logic [9:0]               r_best_x, r_best_y;
    logic [SCORE_W-1:0]       r_best_score;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    assign w_last = (r_x == XW'(IMG_W - 1)) && (r_y == YW'(IMG_H - 1));

    // A start pulse restarts the scan from any state, so it outranks a final pixel.
    always_comb begin
        w_state_d = r_state;
        w_clear   = 1'b0;
        w_accept  = 1'b0;
        w_finish  = 1'b0;
        if (i_start) begin
            w_state_d = StRun;
            w_clear   = 1'b1;
        end else begin
            case (r_state)
                StIdle: w_state_d = StIdle;
                StRun: begin
                    if (i_pix_valid) begin
                        w_accept = 1'b1;
                        if (w_last) begin
                            w_state_d = StFlush;
                        end
                    end
                end
                StFlush: begin
                    w_finish  = 1'b1;
                    w_state_d = StIdle;
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAP; i++) begin
                r_tmpl[i] <= '0;
            end
        end else if (i_tmpl_we && (r_state == StIdle) && (32'(i_tmpl_addr) < NTAP)) begin
            r_tmpl[i_tmpl_addr] <= i_tmpl_data;
        end
    end

    tmpl_window_buffer #(
        .IMG_W (IMG_W),
        .TMPL  (TMPL),
        .PIX_W (PIX_W)
    ) u_window (
        .clk   (clk),
        .i_en  (w_accept),
        .i_col (r_x),
        .i_pix (i_pix),
        .o_win (w_win)
    );

    assign w_cx        = 16'(r_x) - 16'(HALF);
    assign w_cy        = 16'(r_y) - 16'(HALF);
    assign w_complete  = (32'(r_x) >= TMPL - 1) && (32'(r_y) >= TMPL - 1);
    assign w_in_margin = (w_cx >= 16'(MARGIN)) && (w_cx <= 16'(IMG_W - 1 - MARGIN)) &&
                         (w_cy >= 16'(MARGIN)) && (w_cy <= 16'(IMG_H - 1 - MARGIN));
    assign w_in_box    = !i_track_en ||
                         ((w_cx >= {6'b0, i_left}) && (w_cx <= {6'b0, i_right}) &&
                          (w_cy >= {6'b0, i_top})  && (w_cy <= {6'b0, i_bottom}));
    assign w_qual      = w_complete && w_in_margin && w_in_box;

    // Squared magnitude of the signed difference fits in 2*PIX_W bits.
    always_comb begin
        logic [PIX_W:0]     diff;
        logic [PIX_W-1:0]   mag;
        logic [2*PIX_W-1:0] sq;
        w_score = '0;
        diff    = '0;
        mag     = '0;
        sq      = '0;
        for (int i = 0; i < NTAP; i++) begin
            diff    = {1'b0, r_tmpl[i]} - {1'b0, w_win[i*PIX_W +: PIX_W]};
            mag     = diff[PIX_W] ? PIX_W'(-diff) : diff[PIX_W-1:0];
            sq      = (2*PIX_W)'(mag) * (2*PIX_W)'(mag);
            w_score = w_score + SCORE_W'(sq);
        end
    end

    assign w_upd = r_cand_v && (w_score < r_min);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x          <= '0;
            r_y          <= '0;
            r_cand_v     <= 1'b0;
            r_cand_x     <= '0;
            r_cand_y     <= '0;
            r_min        <= '1;
            r_min_x      <= '0;
            r_min_y      <= '0;
            r_found      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_best_valid <= 1'b0;
            r_best_x     <= 10'(IMG_W / 2);
            r_best_y     <= 10'(IMG_H / 2);
            r_best_score <= '1;
        end else begin
            r_done   <= 1'b0;
            r_cand_v <= w_accept && w_qual;
            if (w_accept) begin
                r_cand_x <= w_cx[9:0];
                r_cand_y <= w_cy[9:0];
                if (r_x == XW'(IMG_W - 1)) begin
                    r_x <= '0;
                    r_y <= r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
            if (w_clear) begin
                r_x      <= '0;
                r_y      <= '0;
                r_cand_v <= 1'b0;
                r_min    <= '1;
                r_found  <= 1'b0;
                r_busy   <= 1'b1;
            end else if (w_upd) begin
                r_min   <= w_score;
                r_min_x <= r_cand_x;
                r_min_y <= r_cand_y;
                r_found <= 1'b1;
            end
            // The last window's compare lands in the flush cycle, so fold it in here.
            if (w_finish) begin
                r_busy       <= 1'b0;
                r_done       <= 1'b1;
                r_best_valid <= r_found || w_upd;
                if (r_found || w_upd) begin
                    r_best_x     <= w_upd ? r_cand_x : r_min_x;
                    r_best_y     <= w_upd ? r_cand_y : r_min_y;
                    r_best_score <= w_upd ? w_score  : r_min;
                end
            end
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_best_valid = r_best_valid;
    assign o_best_x     = r_best_x;
    assign o_best_y     = r_best_y;
    assign o_best_score = r_best_score;

endmodule

// File: tb/tb_ssd_template_tracker.sv
// Directed bench for ssd_template_tracker on a 16x12 frame with a 3x3 template.
module tb_ssd_template_tracker;

    localparam int IW   = 16;
    localparam int IH   = 12;
    localparam int NPIX = IW * IH;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, pix_valid, tmpl_we, track_en;
    logic [3:0]  pix, tmpl_addr, tmpl_data;
    logic [9:0]  left, right, top, bottom;
    logic        busy, done, best_valid;
    logic [9:0]  best_x, best_y;
    logic [11:0] best_score;

    logic [3:0]  frame [NPIX];
    int          n_tests, n_fail;

    ssd_template_tracker #(
        .IMG_W  (IW),
        .IMG_H  (IH),
        .TMPL   (3),
        .PIX_W  (4),
        .MARGIN (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start),
        .i_pix_valid  (pix_valid),
        .i_pix        (pix),
        .i_tmpl_we    (tmpl_we),
        .i_tmpl_addr  (tmpl_addr),
        .i_tmpl_data  (tmpl_data),
        .i_track_en   (track_en),
        .i_left       (left),
        .i_right      (right),
        .i_top        (top),
        .i_bottom     (bottom),
        .o_busy       (busy),
        .o_done       (done),
        .o_best_valid (best_valid),
        .o_best_x     (best_x),
        .o_best_y     (best_y),
        .o_best_score (best_score)
    );

    always #5 clk = ~clk;

    task automatic set_frame_patch();
        for (int i = 0; i < NPIX; i++) frame[i] = 4'd0;
        for (int y = 5; y <= 7; y++)
            for (int x = 8; x <= 10; x++) frame[y*IW + x] = 4'd15;
    endtask

    task automatic set_frame_uniform(input logic [3:0] v);
        for (int i = 0; i < NPIX; i++) frame[i] = v;
    endtask

    // Entries 9..15 lie beyond the template and must be dropped.
    task automatic load_template(input logic [3:0] v);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            tmpl_we   = 1'b1;
            tmpl_addr = 4'(i);
            tmpl_data = (i < 9) ? v : 4'd0;
        end
        @(negedge clk);
        tmpl_we = 1'b0;
    endtask

    task automatic feed_pixels(input int n, input bit stall, output int dones);
        int idx   = 0;
        int guard = 0;
        dones = 0;
        while (idx < n && guard < 40 * NPIX) begin
            pix_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            pix       = frame[idx];
            @(negedge clk);
            if (done) dones++;
            if (pix_valid) idx++;
            guard++;
        end
        pix_valid = 1'b0;
    endtask

    // lat counts cycles from the last pixel handshake cycle to the cycle showing done.
    task automatic run_frame(input int n_abort, input bit stall, output int lat,
                             output int dones, output logic busy_seen);
        int d;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        busy_seen = busy;
        dones     = 0;
        if (n_abort > 0) begin
            feed_pixels(n_abort, 1'b0, d);
            dones += d;
            start     = 1'b1;
            tmpl_we   = 1'b1;
            tmpl_addr = 4'd4;
            tmpl_data = 4'd0;
            @(negedge clk);
            start = 1'b0;
            if (done) dones++;
            @(negedge clk);
            tmpl_we = 1'b0;
            if (done) dones++;
        end
        feed_pixels(NPIX, stall, d);
        dones += d;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
        n_tests++; if (best_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", best_valid); end
        n_tests++; if (best_x !== 10'd8) begin n_fail++; $display("FAIL reset_x: got %0d want 8", best_x); end
        n_tests++; if (best_y !== 10'd6) begin n_fail++; $display("FAIL reset_y: got %0d want 6", best_y); end
        n_tests++; if (best_score !== 12'hfff) begin n_fail++; $display("FAIL reset_score: got %0h want fff", best_score); end
    endtask

    task automatic test_patch();
        int lat, dn; logic bs;
        load_template(4'd15);
        set_frame_patch();
        track_en = 1'b0;
        run_frame(0, 1'b0, lat, dn, bs);
        n_tests++; if (bs !== 1'b1) begin n_fail++; $display("FAIL patch_busy: got %0b want 1", bs); end
        n_tests++; if (lat != 2) begin n_fail++; $display("FAIL patch_latency: got %0d want 2", lat); end
        n_tests++; if (dn != 0) begin n_fail++; $display("FAIL patch_early_done: got %0d want 0", dn); end
        n_tests++; if (best_valid !== 1'b1) begin n_fail++; $display("FAIL patch_valid: got %0b want 1", best_valid); end
        n_tests++; if (best_x !== 10'd9) begin n_fail++; $display("FAIL patch_x: got %0d want 9", best_x); end
        n_tests++; if (best_y !== 10'd6) begin n_fail++; $display("FAIL patch_y: got %0d want 6", best_y); end
        n_tests++; if (best_score !== 12'd0) begin n_fail++; $display("FAIL patch_score: got %0d want 0", best_score); end
        @(negedge clk);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL patch_done_pulse: got %0b want 0", done); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL patch_busy_end: got %0b want 0", busy); end
    endtask

    task automatic test_track_box();
        int lat, dn; logic bs;
        track_en = 1'b1; left = 10'd2; right = 10'd5; top = 10'd2; bottom = 10'd5;
        run_frame(0, 1'b0, lat, dn, bs);
        n_tests++; if (best_valid !== 1'b1) begin n_fail++; $display("FAIL box_valid: got %0b want 1", best_valid); end
        n_tests++; if (best_x !== 10'd2) begin n_fail++; $display("FAIL box_x: got %0d want 2", best_x); end
        n_tests++; if (best_y !== 10'd2) begin n_fail++; $display("FAIL box_y: got %0d want 2", best_y); end
        n_tests++; if (best_score !== 12'd2025) begin n_fail++; $display("FAIL box_score: got %0d want 2025", best_score); end
    endtask

    task automatic test_tie();
        int lat, dn; logic bs;
        set_frame_uniform(4'd7);
        track_en = 1'b0;
        run_frame(0, 1'b0, lat, dn, bs);
        n_tests++; if (best_x !== 10'd2) begin n_fail++; $display("FAIL tie_x: got %0d want 2", best_x); end
        n_tests++; if (best_y !== 10'd2) begin n_fail++; $display("FAIL tie_y: got %0d want 2", best_y); end
        n_tests++; if (best_score !== 12'd576) begin n_fail++; $display("FAIL tie_score: got %0d want 576", best_score); end
    endtask

    task automatic test_empty_box();
        int lat, dn; logic bs;
        track_en = 1'b1; left = 10'd0; right = 10'd1; top = 10'd0; bottom = 10'd1;
        run_frame(0, 1'b0, lat, dn, bs);
        n_tests++; if (lat != 2) begin n_fail++; $display("FAIL empty_latency: got %0d want 2", lat); end
        n_tests++; if (best_valid !== 1'b0) begin n_fail++; $display("FAIL empty_valid: got %0b want 0", best_valid); end
        n_tests++; if (best_x !== 10'd2) begin n_fail++; $display("FAIL empty_x_hold: got %0d want 2", best_x); end
        n_tests++; if (best_y !== 10'd2) begin n_fail++; $display("FAIL empty_y_hold: got %0d want 2", best_y); end
        n_tests++; if (best_score !== 12'd576) begin n_fail++; $display("FAIL empty_score_hold: got %0d want 576", best_score); end
    endtask

    task automatic test_abort();
        int lat, dn; logic bs;
        set_frame_patch();
        track_en = 1'b0;
        run_frame(100, 1'b0, lat, dn, bs);
        n_tests++; if (dn != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", dn); end
        n_tests++; if (lat != 2) begin n_fail++; $display("FAIL abort_latency: got %0d want 2", lat); end
        n_tests++; if (best_valid !== 1'b1) begin n_fail++; $display("FAIL abort_valid: got %0b want 1", best_valid); end
        n_tests++; if (best_x !== 10'd9) begin n_fail++; $display("FAIL abort_x: got %0d want 9", best_x); end
        n_tests++; if (best_y !== 10'd6) begin n_fail++; $display("FAIL abort_y: got %0d want 6", best_y); end
        n_tests++; if (best_score !== 12'd0) begin n_fail++; $display("FAIL abort_tmpl_kept: got %0d want 0", best_score); end
    endtask

    task automatic test_stall();
        int lat, dn; logic bs;
        set_frame_uniform(4'd7);
        track_en = 1'b0;
        run_frame(0, 1'b0, lat, dn, bs);
        set_frame_patch();
        run_frame(0, 1'b1, lat, dn, bs);
        n_tests++; if (lat != 2) begin n_fail++; $display("FAIL stall_latency: got %0d want 2", lat); end
        n_tests++; if (best_x !== 10'd9) begin n_fail++; $display("FAIL stall_x: got %0d want 9", best_x); end
        n_tests++; if (best_y !== 10'd6) begin n_fail++; $display("FAIL stall_y: got %0d want 6", best_y); end
        n_tests++; if (best_score !== 12'd0) begin n_fail++; $display("FAIL stall_score: got %0d want 0", best_score); end
    endtask

    task automatic test_reset_mid();
        int lat, dn; logic bs;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        feed_pixels(50, 1'b0, dn);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %0b want 0", busy); end
        n_tests++; if (best_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %0b want 0", best_valid); end
        n_tests++; if (best_x !== 10'd8) begin n_fail++; $display("FAIL rmid_x: got %0d want 8", best_x); end
        n_tests++; if (best_score !== 12'hfff) begin n_fail++; $display("FAIL rmid_score: got %0h want fff", best_score); end
        rst_n = 1'b1;
        // Template is cleared to zero now, so the first all-zero window wins.
        run_frame(0, 1'b0, lat, dn, bs);
        n_tests++; if (best_x !== 10'd2) begin n_fail++; $display("FAIL rmid_tmpl_x: got %0d want 2", best_x); end
        n_tests++; if (best_y !== 10'd2) begin n_fail++; $display("FAIL rmid_tmpl_y: got %0d want 2", best_y); end
        n_tests++; if (best_score !== 12'd0) begin n_fail++; $display("FAIL rmid_tmpl_score: got %0d want 0", best_score); end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix = '0;
        tmpl_we = 1'b0; tmpl_addr = '0; tmpl_data = '0; track_en = 1'b0;
        left = '0; right = '0; top = '0; bottom = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_patch();
        test_track_box();
        test_tie();
        test_empty_box();
        test_abort();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
